// File: rtl/alu_acc_seq.sv
// Accumulator ALU: WIDTH-bit datapath, 16 ops, registered Acc/carry/zero, start/busy/done handshake.
// Latency: 1 edge for single-cycle ops, WIDTH+1 edges for iterative multiply/divide.
// Backpressure: start is ignored while busy; requests are neither queued nor flagged.
module alu_acc_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             src_acc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] Acc,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [WIDTH-1:0]     dvsr_r;
    logic [WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]     quo_r;

    logic [WIDTH-1:0]     x;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       dif;
    logic [WIDTH-1:0]     r;
    logic                 c;

    logic [2*WIDTH-1:0]   prod_nxt;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_dif;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     quo_nxt;
    logic [WIDTH-1:0]     div_res;
    logic                 last_iter;

    // Single-cycle result; ops 2/3 are produced by the iterative datapath below.
    always_comb begin
        x   = src_acc ? Acc : A;
        sum = {1'b0, x} + {1'b0, B};
        dif = {1'b0, x} - {1'b0, B};
        r   = '0;
        c   = 1'b0;
        case (ALU_Sel)
            4'd0:  begin r = sum[WIDTH-1:0]; c = sum[WIDTH]; end
            4'd1:  begin r = dif[WIDTH-1:0]; c = dif[WIDTH]; end
            4'd4:  begin r = {x[WIDTH-2:0], 1'b0}; c = x[WIDTH-1]; end
            4'd5:  begin r = {1'b0, x[WIDTH-1:1]}; c = x[0]; end
            4'd6:  begin r = {x[WIDTH-2:0], x[WIDTH-1]}; c = x[WIDTH-1]; end
            4'd7:  begin r = {x[0], x[WIDTH-1:1]}; c = x[0]; end
            4'd8:  r = x & B;
            4'd9:  r = x | B;
            4'd10: r = x ^ B;
            4'd11: r = ~(x | B);
            4'd12: r = ~(x & B);
            4'd13: r = ~(x ^ B);
            4'd14: r = {{(WIDTH-1){1'b0}}, (x > B)};
            4'd15: r = {{(WIDTH-1){1'b0}}, (x == B)};
            default: begin r = '0; c = 1'b0; end
        endcase
    end

    // One shift-add step and one restoring-divide step per cycle.
    always_comb begin
        prod_nxt  = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
        rem_sh    = {rem_r, quo_r[WIDTH-1]};
        rem_ge    = (rem_sh >= {1'b0, dvsr_r});
        rem_dif   = rem_sh[WIDTH-1:0] - dvsr_r;
        rem_nxt   = rem_ge ? rem_dif : rem_sh[WIDTH-1:0];
        quo_nxt   = {quo_r[WIDTH-2:0], rem_ge};
        div_res   = (dvsr_r == '0) ? '1 : quo_nxt;
        last_iter = (cnt_r == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt_r    <= '0;
            mcand_r  <= '0;
            prod_r   <= '0;
            mplier_r <= '0;
            dvsr_r   <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            Acc      <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ALU_Sel == 4'd2) begin
                            mcand_r  <= {{WIDTH{1'b0}}, x};
                            mplier_r <= B;
                            prod_r   <= '0;
                            cnt_r    <= '0;
                            busy     <= 1'b1;
                            state    <= MUL;
                        end else if (ALU_Sel == 4'd3) begin
                            quo_r  <= x;
                            dvsr_r <= B;
                            rem_r  <= '0;
                            cnt_r  <= '0;
                            busy   <= 1'b1;
                            state  <= DIV;
                        end else begin
                            Acc   <= r;
                            carry <= c;
                            zero  <= (r == '0);
                            done  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod_r   <= prod_nxt;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_iter) begin
                        Acc   <= prod_nxt[WIDTH-1:0];
                        carry <= |prod_nxt[2*WIDTH-1:WIDTH];
                        zero  <= (prod_nxt[WIDTH-1:0] == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DIV: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_iter) begin
                        Acc   <= div_res;
                        carry <= (dvsr_r == '0);
                        zero  <= (div_res == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
